chacha20_round_engine: RTL

Iterative ChaCha20 core permutation. It produces the 512-bit unmixed_round_output that chacha20_mixing_function adds to round_input. It latches a 16-word input state, applies 2*DOUBLE_ROUNDS rounds at one full round per cycle, and alternates column and diagonal rounds. It presents the permuted state alongside the latched original state, so the downstream mixing stage needs no separate copy.

---
 rtl/chacha20_round_engine.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/chacha20_round_engine.sv
// ChaCha20 iterative round engine: one full (column or diagonal) round per
// cycle over a 16-word work register, with the original input held alongside
// the permuted state for the downstream mixing add.
module chacha20_round_engine #(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] round_input,
  output logic         busy,
  output logic         done,
  output logic [511:0] unmixed_round_output,
  output logic [511:0] held_input
);

  localparam int unsigned NUM_ROUNDS = 2 * DOUBLE_ROUNDS;
  localparam int unsigned CTR_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_WORDS  = 16;

  localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(NUM_ROUNDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [511:0]     work_q, work_d;
  logic [511:0]     held_q, held_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // 32-bit rotate left by a fixed amount (1..31)
  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v,
                                             input int unsigned n);
    rotl = (v << n) | (v >> (WORD_W - n));
  endfunction

  // Quarter round; result packed as {d, c, b, a}
  function automatic logic [4*WORD_W-1:0] qr(input logic [WORD_W-1:0] a_in,
                                             input logic [WORD_W-1:0] b_in,
                                             input logic [WORD_W-1:0] c_in,
                                             input logic [WORD_W-1:0] d_in);
    logic [WORD_W-1:0] a, b, c, d;
    a = a_in;
    b = b_in;
    c = c_in;
    d = d_in;
    a = a + b; d = d ^ a; d = rotl(d, 16);
    c = c + d; b = b ^ c; b = rotl(b, 12);
    a = a + b; d = d ^ a; d = rotl(d, 8);
    c = c + d; b = b ^ c; b = rotl(b, 7);
    qr = {d, c, b, a};
  endfunction

  // One full round; the four quarter rounds touch disjoint words so in-place
  // update is equivalent to evaluating all of them from the current state
  function automatic logic [511:0] round_fn(input logic [511:0] s,
                                            input logic diag);
    logic [WORD_W-1:0] w [NUM_WORDS];
    logic [511:0]      r;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      w[i] = s[WORD_W*i +: WORD_W];
    end
    if (!diag) begin
      {w[12], w[8],  w[4], w[0]} = qr(w[0], w[4], w[8],  w[12]);
      {w[13], w[9],  w[5], w[1]} = qr(w[1], w[5], w[9],  w[13]);
      {w[14], w[10], w[6], w[2]} = qr(w[2], w[6], w[10], w[14]);
      {w[15], w[11], w[7], w[3]} = qr(w[3], w[7], w[11], w[15]);
    end else begin
      {w[15], w[10], w[5], w[0]} = qr(w[0], w[5], w[10], w[15]);
      {w[12], w[11], w[6], w[1]} = qr(w[1], w[6], w[11], w[12]);
      {w[13], w[8],  w[7], w[2]} = qr(w[2], w[7], w[8],  w[13]);
      {w[14], w[9],  w[4], w[3]} = qr(w[3], w[4], w[9],  w[14]);
    end
    r = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      r[WORD_W*i +: WORD_W] = w[i];
    end
    round_fn = r;
  endfunction

  // Next-state, datapath and registered-output control
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    work_d  = work_q;
    held_d  = held_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d  = round_input;
          held_d  = round_input;
          ctr_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        work_d = round_fn(work_q, ctr_q[0]);
        if (ctr_q == LAST_CTR) begin
          // Hold the counter at its last value so it never wraps
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      work_q  <= '0;
      held_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      work_q  <= work_d;
      held_q  <= held_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign unmixed_round_output = work_q;
  assign held_input           = held_q;

endmodule
